// File: rtl/bram_stream_defs.sv
// Shared definitions for the block-RAM stream reader: FSM encodings and
// the address-width derivation used by the reader and its RAM port.
package bram_stream_defs;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // One extra bit so a length of exactly Depth words is representable.
    function automatic int addr_width_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_stream_reader_chk.sv
// Protocol checks for the stream reader: caller base-address range and
// output-buffer overflow.
module bram_stream_reader_chk
    import bram_stream_defs::*;
#(
    parameter int AddrWidth = 11,
    parameter int Depth     = 1024
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic [1:0]           state_i,
    input logic                 start_i,
    input logic [AddrWidth-1:0] base_addr_i,
    input logic                 push_i,
    input logic                 pop_i,
    input logic [1:0]           count_i
);

    a_base_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (start_i && (state_i == ST_IDLE)) |-> (base_addr_i < AddrWidth'(Depth)));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && (count_i == 2'd2)));

endmodule

// File: rtl/stream_fifo2.sv
// Two-entry FIFO carrying a data word plus a last tag; the head entry is
// always presented on the outputs. Reusable by any RAM read-port consumer.
module stream_fifo2 #(
    parameter int DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 push_last_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] head_data_o,
    output logic                 head_last_o,
    output logic [1:0]           count_o,
    output logic                 empty_o
);

    logic [DataWidth-1:0] head_data_r;
    logic                 head_last_r;
    logic [DataWidth-1:0] tail_data_r;
    logic                 tail_last_r;
    logic [1:0]           count_r;
    logic                 pop_s;

    // A pop on an empty FIFO is meaningless, so it is masked here.
    always_comb begin
        pop_s = 1'b0;
        if (pop_i && (count_r != 2'd0)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Entry storage and occupancy update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_data_r <= {DataWidth{1'b0}};
            head_last_r <= 1'b0;
            tail_data_r <= {DataWidth{1'b0}};
            tail_last_r <= 1'b0;
            count_r     <= 2'd0;
        end else begin
            case ({push_i, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_data_r <= push_data_i;
                        head_last_r <= push_last_i;
                        count_r     <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        tail_data_r <= push_data_i;
                        tail_last_r <= push_last_i;
                        count_r     <= 2'd2;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    head_data_r <= tail_data_r;
                    head_last_r <= tail_last_r;
                    count_r     <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        head_data_r <= tail_data_r;
                        head_last_r <= tail_last_r;
                        tail_data_r <= push_data_i;
                        tail_last_r <= push_last_i;
                    end else begin
                        head_data_r <= push_data_i;
                        head_last_r <= push_last_i;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head_data_o = head_data_r;
    assign head_last_o = head_last_r;
    assign count_o     = count_r;
    assign empty_o     = (count_r == 2'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// Streams (base, length) worth of words from a registered-read block RAM
// onto a valid/ready interface, hiding the RAM latency behind a 2-entry buffer.
module bram_stream_reader
    import bram_stream_defs::*;
#(
    parameter int   DataWidth = 8,
    parameter int   Depth     = 1024,
    localparam int  AddrWidth = addr_width_f(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [AddrWidth-1:0] length_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AddrWidth-1:0] bram_addr_o,
    input  logic [DataWidth-1:0] bram_data_i,
    output logic [DataWidth-1:0] m_data_o,
    output logic                 m_valid_o,
    output logic                 m_last_o,
    input  logic                 m_ready_i
);

    localparam logic [AddrWidth-1:0] AddrZero = {AddrWidth{1'b0}};
    localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);
    localparam logic [AddrWidth-1:0] AddrLast = AddrWidth'(Depth - 1);

    logic [1:0]           state_r;
    logic [AddrWidth-1:0] addr_r;
    logic [AddrWidth-1:0] last_addr_r;
    logic [AddrWidth-1:0] issued_r;
    logic [AddrWidth-1:0] len_r;
    logic                 inflight_r;
    logic                 inflight_last_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 pop_s;
    logic                 issue_s;
    logic                 issue_last_s;
    logic [2:0]           occupancy_s;
    logic [AddrWidth-1:0] next_addr_s;
    logic [1:0]           count_s;
    logic                 empty_s;
    logic [DataWidth-1:0] head_data_s;
    logic                 head_last_s;

    // Occupancy after this cycle = buffered + arriving - leaving; a read may
    // only be issued while that leaves room for its data next cycle.
    always_comb begin
        pop_s        = !empty_s && m_ready_i;
        occupancy_s  = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        if ((state_r == ST_STREAM) && (issued_r < len_r) && (occupancy_s < 3'd2)) begin
            issue_s      = 1'b1;
            issue_last_s = ((issued_r + AddrOne) == len_r);
        end else begin
            issue_s      = 1'b0;
            issue_last_s = 1'b0;
        end
        if (addr_r == AddrLast) begin
            next_addr_s = AddrZero;
        end else begin
            next_addr_s = addr_r + AddrOne;
        end
        if (issue_s) begin
            bram_addr_o = addr_r;
        end else begin
            bram_addr_o = last_addr_r;
        end
    end

    // Transfer FSM, address/length bookkeeping and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            addr_r      <= AddrZero;
            last_addr_r <= AddrZero;
            issued_r    <= AddrZero;
            len_r       <= AddrZero;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        if (length_i != AddrZero) begin
                            addr_r   <= base_addr_i;
                            len_r    <= length_i;
                            issued_r <= AddrZero;
                            busy_r   <= 1'b1;
                            state_r  <= ST_STREAM;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (issue_s) begin
                        last_addr_r <= addr_r;
                        addr_r      <= next_addr_s;
                        issued_r    <= issued_r + AddrOne;
                        if (issue_last_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish on the edge that empties the pipeline so done_o
                    // lands in the cycle right after the final handshake.
                    if (occupancy_s == 3'd0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Tracks the single outstanding RAM read and whether it is the final word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_last_s;
        end
    end

    stream_fifo2 #(
        .DataWidth (DataWidth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (inflight_r),
        .push_data_i (bram_data_i),
        .push_last_i (inflight_last_r),
        .pop_i       (pop_s),
        .head_data_o (head_data_s),
        .head_last_o (head_last_s),
        .count_o     (count_s),
        .empty_o     (empty_s)
    );

    bram_stream_reader_chk #(
        .AddrWidth (AddrWidth),
        .Depth     (Depth)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .state_i     (state_r),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .push_i      (inflight_r),
        .pop_i       (pop_s),
        .count_i     (count_s)
    );

    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign m_data_o  = head_data_s;
    assign m_last_o  = head_last_s;
    assign m_valid_o = !empty_s;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised self-checking bench for bram_stream_reader against a queue-based
// model of the expected word stream.
module tb_bram_stream_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW-1:0] length_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] bram_addr_o;
    logic [DW-1:0] bram_data_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;

    always #5 clk_i = ~clk_i;

    bram_stream_reader #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bram_addr_o (bram_addr_o),
        .bram_data_i (bram_data_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_last_o    (m_last_o),
        .m_ready_i   (m_ready_i)
    );

    // Registered-read RAM model.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk_i) bram_data_i <= ram[bram_addr_o[3:0]];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [8:0] exp_q [$];
    int         ready_mode = 0;
    int         rpat_idx   = 0;
    logic [5:0] rpat       = 6'b101001;
    int         neg_idx    = 0;
    int         last_hs_idx = 0;
    int         xfer_hs    = 0;
    int         done_cnt   = 0;
    int         cur_len    = 0;

    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                0: m_ready_i = 1'b1;
                1: begin
                    m_ready_i = rpat[rpat_idx % 6];
                    rpat_idx++;
                end
                default: m_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard, stall stability, done timing.
    initial begin
        logic       prev_stall;
        logic       prev_last_hs;
        logic [8:0] prev_word;
        logic [8:0] exp_w;
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
        prev_word    = 9'd0;
        forever begin
            @(negedge clk_i);
            neg_idx++;
            if (!rst_ni) begin
                prev_stall   = 1'b0;
                prev_last_hs = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_valid", 32'(m_valid_o), 32'd1);
                    check_eq("stall_word", 32'({m_last_o, m_data_o}), 32'(prev_word));
                end
                if (done_o) begin
                    done_cnt++;
                    check_eq("done_busy", 32'(busy_o), 32'd0);
                    if (cur_len > 0) check_eq("done_lat", 32'(prev_last_hs), 32'd1);
                end
                prev_last_hs = 1'b0;
                if (m_valid_o && m_ready_i) begin
                    check_eq("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_w = exp_q.pop_front();
                        check_eq("word", 32'({m_last_o, m_data_o}), 32'(exp_w));
                    end
                    if (ready_mode == 0 && xfer_hs > 0)
                        check_eq("gap", 32'(neg_idx - last_hs_idx), 32'd1);
                    last_hs_idx  = neg_idx;
                    xfer_hs++;
                    prev_last_hs = m_last_o;
                end
                prev_stall = m_valid_o && !m_ready_i;
                prev_word  = {m_last_o, m_data_o};
            end
        end
    end

    task automatic load_expect(input int base, input int len);
        for (int k = 0; k < len; k++)
            exp_q.push_back({(k == len - 1) ? 1'b1 : 1'b0, ram[(base + k) % DEPTH]});
        cur_len  = len;
        done_cnt = 0;
        xfer_hs  = 0;
    endtask

    task automatic run_transfer(input int base, input int len, input bit inject);
        int lat;
        int budget;
        load_expect(base, len);
        @(posedge clk_i);
        #1;
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        length_i    = AW'(len);
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        base_addr_i = AW'($urandom_range(0, DEPTH - 1));
        length_i    = AW'($urandom_range(1, 31));
        if (len == 0) begin
            @(negedge clk_i);
            check_eq("len0_done", 32'(done_o), 32'd1);
            check_eq("len0_busy", 32'(busy_o), 32'd0);
            check_eq("len0_valid", 32'(m_valid_o), 32'd0);
            @(negedge clk_i);
            check_eq("len0_busy2", 32'(busy_o), 32'd0);
            check_eq("len0_valid2", 32'(m_valid_o), 32'd0);
        end else begin
            @(negedge clk_i);
            check_eq("busy_start", 32'(busy_o), 32'd1);
            lat = 0;
            while (!m_valid_o && lat < 10) begin
                @(posedge clk_i);
                lat++;
                @(negedge clk_i);
            end
            check_eq("first_valid_lat", 32'(lat), 32'd2);
            if (inject) begin
                @(posedge clk_i);
                #1;
                start_i     = 1'b1;
                base_addr_i = AW'((base + 7) % DEPTH);
                length_i    = AW'(3);
                repeat (3) @(posedge clk_i);
                #1;
                start_i = 1'b0;
            end
        end
        budget = len * 20 + 40;
        while (done_cnt == 0 && budget > 0) begin
            @(posedge clk_i);
            budget--;
        end
        repeat (3) @(negedge clk_i);
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("words_left", 32'(exp_q.size()), 32'd0);
        check_eq("busy_end", 32'(busy_o), 32'd0);
        check_eq("valid_end", 32'(m_valid_o), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int budget;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        length_i    = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 16);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("reset_outputs",
                 32'({busy_o, done_o, m_valid_o, m_last_o, m_data_o, bram_addr_o}), 32'd0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;

        run_transfer(3, 5, 1'b0);
        run_transfer(14, 4, 1'b0);
        ready_mode = 1;
        rpat_idx   = 0;
        run_transfer(2, 6, 1'b0);
        ready_mode = 0;
        run_transfer(7, 0, 1'b0);
        run_transfer(1, 8, 1'b1);

        // Abort after two words; no done may follow.
        load_expect(5, 8);
        @(posedge clk_i);
        #1;
        start_i     = 1'b1;
        base_addr_i = AW'(5);
        length_i    = AW'(8);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        budget  = 40;
        while (xfer_hs < 2 && budget > 0) begin
            @(negedge clk_i);
            budget--;
        end
        check_eq("abort_hs", 32'(xfer_hs), 32'd2);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("abort_outputs",
                 32'({busy_o, done_o, m_valid_o, m_last_o, m_data_o, bram_addr_o}), 32'd0);
        exp_q.delete();
        done_cnt = 0;
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        repeat (12) @(negedge clk_i);
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        run_transfer(9, 6, 1'b0);

        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
        ready_mode = 2;
        for (int t = 0; t < 12; t++)
            run_transfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 31)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
